// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, carry-op classification
// and controller state encoding.
package alu_arbiter_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_XOR = 8'h06;
  localparam logic [7:0] OP_NOT = 8'h07;
  localparam logic [7:0] OP_ROR = 8'h08;
  localparam logic [7:0] OP_ROL = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0A;
  localparam logic [7:0] OP_INC = 8'h0B;
  localparam logic [7:0] OP_RSH = 8'h0C;
  localparam logic [7:0] OP_LSH = 8'h0D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The ALU only drives a meaningful carry for these opcodes.
  function automatic logic is_carry_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_RSH) || (op == OP_LSH);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_idx = grant[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, with
// registered ALU inputs, captured results and per-requester carry history.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int                 DATA_W  = 16,
  parameter int                 INSTR_W = 8,
  parameter logic [INSTR_W-1:0] MAX_OP  = 8'h0D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DATA_W-1:0]  req_op1,
  input  logic [2*DATA_W-1:0]  req_op2,
  input  logic [2*INSTR_W-1:0] req_instr,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [DATA_W-1:0]    resp_out,
  output logic                 resp_carry,
  output logic                 resp_parity,
  output logic                 resp_eq,
  output logic                 resp_gt,
  output logic                 resp_err,
  output logic [DATA_W-1:0]    alu_op1,
  output logic [DATA_W-1:0]    alu_op2,
  output logic [INSTR_W-1:0]   alu_instruction,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_carry,
  input  logic                 alu_parity,
  input  logic                 alu_eq,
  input  logic                 alu_gt
);

  state_t            state;
  logic              last_grant;
  logic              tag;
  logic              illegal_q;
  logic [1:0]        carry_hold;
  logic [DATA_W-1:0] last_out [2];

  logic [1:0]         grant;
  logic               grant_idx;
  logic [DATA_W-1:0]  sel_op1;
  logic [DATA_W-1:0]  sel_op2;
  logic [INSTR_W-1:0] sel_instr;
  logic               sel_illegal;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready   = (state == IDLE) ? grant : 2'b00;
  assign sel_op1     = grant_idx ? req_op1[DATA_W +: DATA_W]    : req_op1[0 +: DATA_W];
  assign sel_op2     = grant_idx ? req_op2[DATA_W +: DATA_W]    : req_op2[0 +: DATA_W];
  assign sel_instr   = grant_idx ? req_instr[INSTR_W +: INSTR_W] : req_instr[0 +: INSTR_W];
  assign sel_illegal = sel_instr > MAX_OP;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      tag             <= 1'b0;
      illegal_q       <= 1'b0;
      carry_hold      <= 2'b00;
      // NOTE: last_out is a tiny register file that is deliberately reset, because
      // a NOP issued right after reset returns it.
      last_out[0]     <= '0;
      last_out[1]     <= '0;
      resp_valid      <= 2'b00;
      resp_out        <= '0;
      resp_carry      <= 1'b0;
      resp_parity     <= 1'b0;
      resp_eq         <= 1'b0;
      resp_gt         <= 1'b0;
      resp_err        <= 1'b0;
      alu_op1         <= '0;
      alu_op2         <= '0;
      alu_instruction <= OP_NOP;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            alu_op1         <= sel_op1;
            alu_op2         <= sel_op2;
            // Illegal opcodes never reach the ALU.
            alu_instruction <= sel_illegal ? OP_NOP : sel_instr;
            illegal_q       <= sel_illegal;
            tag             <= grant_idx;
            state           <= EXEC;
          end
        end
        EXEC: begin
          if (illegal_q) begin
            resp_out    <= '0;
            resp_carry  <= 1'b0;
            resp_parity <= 1'b0;
            resp_eq     <= 1'b0;
            resp_gt     <= 1'b0;
            resp_err    <= 1'b1;
          end else if (alu_instruction == OP_NOP) begin
            // The ALU output is not trusted for NOP; replay the requester's history.
            resp_out    <= last_out[tag];
            resp_carry  <= carry_hold[tag];
            resp_parity <= ^last_out[tag];
            resp_eq     <= 1'b0;
            resp_gt     <= 1'b0;
            resp_err    <= 1'b0;
          end else begin
            resp_out    <= alu_out;
            resp_parity <= alu_parity;
            resp_eq     <= alu_eq;
            resp_gt     <= alu_gt;
            resp_err    <= 1'b0;
            if (is_carry_op(alu_instruction)) begin
              resp_carry      <= alu_carry;
              carry_hold[tag] <= alu_carry;
            end else begin
              resp_carry      <= carry_hold[tag];
            end
            last_out[tag] <= alu_out;
          end
          resp_valid[tag] <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (resp_ready[tag]) begin
            resp_valid      <= 2'b00;
            last_grant      <= tag;
            alu_instruction <= OP_NOP;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural 8-bit ALU model, a table of
// single-op vectors, and hand-written stall, reset and round-robin sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [15:0] req_instr;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_out;
  logic        resp_carry, resp_parity, resp_eq, resp_gt, resp_err;
  logic [15:0] alu_op1, alu_op2;
  logic [7:0]  alu_instruction;
  logic [15:0] alu_out;
  logic        alu_carry, alu_parity, alu_eq, alu_gt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_instr(req_instr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_carry(resp_carry), .resp_parity(resp_parity),
    .resp_eq(resp_eq), .resp_gt(resp_gt), .resp_err(resp_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instruction(alu_instruction),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_parity(alu_parity),
    .alu_eq(alu_eq), .alu_gt(alu_gt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 8-bit datapath, MUL gives a 16-bit product, carry is 0
  // for ops that do not produce one.
  logic [7:0] m_a, m_b;
  logic [8:0] m_w;
  assign m_a = alu_op1[7:0];
  assign m_b = alu_op2[7:0];

  always_comb begin
    m_w       = 9'd0;
    alu_out   = 16'h0000;
    alu_carry = 1'b0;
    case (alu_instruction)
      OP_ADD: begin m_w = {1'b0, m_a} + {1'b0, m_b}; alu_out = {8'h00, m_w[7:0]}; alu_carry = m_w[8]; end
      OP_SUB: begin m_w = {1'b0, m_a} - {1'b0, m_b}; alu_out = {8'h00, m_w[7:0]}; alu_carry = m_w[8]; end
      OP_MUL: alu_out = {8'h00, m_a} * {8'h00, m_b};
      OP_OR:  alu_out = {8'h00, m_a | m_b};
      OP_AND: alu_out = {8'h00, m_a & m_b};
      OP_XOR: alu_out = {8'h00, m_a ^ m_b};
      OP_NOT: alu_out = {8'h00, ~m_a};
      OP_ROR: begin alu_out = {8'h00, m_a[0], m_a[7:1]}; alu_carry = m_a[0]; end
      OP_ROL: begin alu_out = {8'h00, m_a[6:0], m_a[7]}; alu_carry = m_a[7]; end
      OP_INC: alu_out = {8'h00, m_a + 8'd1};
      OP_RSH: begin alu_out = {8'h00, 1'b0, m_a[7:1]};   alu_carry = m_a[0]; end
      OP_LSH: begin alu_out = {8'h00, m_a[6:0], 1'b0};   alu_carry = m_a[7]; end
      default: alu_out = 16'h0000;
    endcase
    alu_parity = ^alu_out;
    alu_eq     = (m_a == m_b);
    alu_gt     = (m_a > m_b);
  end

  typedef struct packed {
    logic        r;
    logic [7:0]  op;
    logic [7:0]  ai;    // alu_instruction expected while the op is in flight
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        c;
    logic        p;
    logic        eq;
    logic        gt;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm, input int r);
    int waited;
    waited = 0;
    #1;
    while (!req_ready[r] && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    check({nm, ".ready"}, {30'd0, req_ready}, (r == 1) ? 32'h2 : 32'h1);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int r;
    r = int'(v.r);
    @(negedge clk);
    req_valid[r]          = 1'b1;
    req_op1[r*16 +: 16]   = v.a;
    req_op2[r*16 +: 16]   = v.b;
    req_instr[r*8 +: 8]   = v.op;
    wait_ready(nm, r);
    @(negedge clk);
    req_valid[r] = 1'b0;
    check({nm, ".exec_valid"}, {30'd0, resp_valid}, 32'h0);
    check({nm, ".exec_instr"}, {24'd0, alu_instruction}, {24'd0, v.ai});
    @(negedge clk);
    check({nm, ".valid"}, {30'd0, resp_valid}, (r == 1) ? 32'h2 : 32'h1);
    check({nm, ".out"},   {16'd0, resp_out}, {16'd0, v.out});
    check({nm, ".flags"}, {27'd0, resp_carry, resp_parity, resp_eq, resp_gt, resp_err},
                          {27'd0, v.c, v.p, v.eq, v.gt, v.err});
    check({nm, ".resp_instr"}, {24'd0, alu_instruction}, {24'd0, v.ai});
    resp_ready[r] = 1'b1;
    @(negedge clk);
    resp_ready[r] = 1'b0;
    check({nm, ".done_valid"}, {30'd0, resp_valid}, 32'h0);
    check({nm, ".done_instr"}, {24'd0, alu_instruction}, 32'h0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".valid"}, {28'd0, resp_valid, req_ready}, 32'h0);
    check({nm, ".resp"},  {11'd0, resp_out, resp_carry, resp_parity, resp_eq, resp_gt, resp_err}, 32'h0);
    check({nm, ".alu_ops"}, {alu_op1, alu_op2}, 32'h0);
    check({nm, ".alu_instr"}, {24'd0, alu_instruction}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_idx [4];
    int g_cyc [4];
    int r_bits [4];
    int r_cyc [4];
    logic [15:0] r_out [4];
    int ng, nr;

    //             r     op      ai      a         b         out       c     p     eq    gt    err
    vecs[0]  = '{1'b0, OP_ADD, OP_ADD, 16'h00F0, 16'h0020, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, OP_AND, OP_AND, 16'h000F, 16'h003C, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, OP_AND, OP_AND, 16'h000F, 16'h003C, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, OP_SUB, OP_SUB, 16'h0010, 16'h0020, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, OP_MUL, OP_MUL, 16'h0012, 16'h0010, 16'h0120, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, OP_XOR, OP_XOR, 16'h0055, 16'h0055, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, OP_LSH, OP_LSH, 16'h0081, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, OP_RSH, OP_RSH, 16'h0002, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, OP_NOP, OP_NOP, 16'h00FF, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, OP_ROL, OP_ROL, 16'h0080, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, OP_ROR, OP_ROR, 16'h0001, 16'h0001, 16'h0080, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, OP_INC, OP_INC, 16'h007F, 16'h0000, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h20,  OP_NOP, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, OP_NOP, OP_NOP, 16'h0000, 16'h0000, 16'h0080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_op1    = '0;
    req_op2    = '0;
    req_instr  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Response stall: r0 OR held in RESP for 5 cycles while r1 waits.
    @(negedge clk);
    req_valid[0]    = 1'b1;
    req_op1[15:0]   = 16'h0030;
    req_op2[15:0]   = 16'h0003;
    req_instr[7:0]  = OP_OR;
    wait_ready("stall", 0);
    @(negedge clk);
    req_valid       = 2'b10;
    req_op1[31:16]  = 16'h000F;
    req_op2[31:16]  = 16'h003C;
    req_instr[15:8] = OP_AND;
    resp_ready      = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall.valid", {30'd0, resp_valid}, 32'h1);
      check("stall.out",   {16'd0, resp_out}, 32'h0033);
      check("stall.no_grant", {30'd0, req_ready}, 32'h0);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk); #1;
    resp_ready[0] = 1'b0;
    check("stall.release_valid", {30'd0, resp_valid}, 32'h0);
    check("stall.release_grant", {30'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("stall.r1_valid", {30'd0, resp_valid}, 32'h2);
    check("stall.r1_out",   {16'd0, resp_out}, 32'h000C);
    @(negedge clk);
    resp_ready = 2'b00;

    // Leave last_grant at requester 0 so the post-reset tie proves the reset value.
    run_op("pre_reset", vecs[0]);

    // Reset during EXEC of a MUL.
    @(negedge clk);
    req_valid[0]   = 1'b1;
    req_op1[15:0]  = 16'h0012;
    req_op2[15:0]  = 16'h0010;
    req_instr[7:0] = OP_MUL;
    wait_ready("rst_mul", 0);
    @(negedge clk);
    req_valid = 2'b00;
    check("rst_mul.in_exec", {24'd0, alu_instruction}, {24'd0, OP_MUL});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mul");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mul.no_resp", {30'd0, resp_valid}, 32'h0);
    end

    // Both requesters valid continuously with resp_ready high: 0,1,0,1.
    ng = 0;
    nr = 0;
    @(negedge clk);
    req_op1    = {16'h0003, 16'h0001};
    req_op2    = {16'h0003, 16'h0001};
    req_instr  = {OP_ADD, OP_ADD};
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (ng == 4) req_valid = 2'b00;
      #1;
      if (req_ready != 2'b00 && ng < 4) begin
        g_idx[ng] = int'(req_ready[1]);
        g_cyc[ng] = k;
        ng++;
      end
      if (resp_valid != 2'b00 && nr < 4) begin
        r_bits[nr] = int'(resp_valid);
        r_cyc[nr]  = k;
        r_out[nr]  = resp_out;
        nr++;
      end
    end
    resp_ready = 2'b00;
    check("rr.grants_seen", ng, 4);
    check("rr.resps_seen",  nr, 4);
    if (ng == 4 && nr == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr.grant%0d", i), g_idx[i], i % 2);
        check($sformatf("rr.spacing%0d", i), g_cyc[i] - g_cyc[0], 3 * i);
        check($sformatf("rr.latency%0d", i), r_cyc[i] - g_cyc[i], 2);
        check($sformatf("rr.owner%0d", i), r_bits[i], (i % 2 == 1) ? 2 : 1);
        check($sformatf("rr.out%0d", i), {16'd0, r_out[i]}, (i % 2 == 1) ? 32'h6 : 32'h2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
